// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation control path: operand width,
// FSM state encoding and the default RUN timeout.
package rsa_pkg;

  localparam int unsigned BITS            = 128;
  localparam int unsigned DEFAULT_TIMEOUT = 32'd4_000_000;

  // Encoding is visible to the host through the STATE debug readback.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_START    = 3'd3,
    ST_RUN      = 3'd4,
    ST_COMPLETE = 3'd5,
    ST_FAULT    = 3'd6,
    ST_ABORTED  = 3'd7
  } state_e;

endpackage

// File: rtl/rsa_cycle_counter.sv
// Saturating cycle counter with synchronous clear and an equality flag
// against a run-time limit.
module rsa_cycle_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Sticks at all-ones so a long run never reads back as a short one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_limit);

endmodule

// File: rtl/rsa_sequencer.sv
// Control FSM for the RSA modexp core: clear/load/start strobes, DONE edge
// detection, timeout supervision and host status reporting.
module rsa_sequencer
  import rsa_pkg::*;
#(
  parameter int unsigned      CNT_W          = 32,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = CNT_W'(DEFAULT_TIMEOUT)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CMD_START,
  input  logic             CMD_ABORT,
  input  logic             CMD_ACK,
  input  logic             DONE,
  output logic             LOAD,
  output logic             CLR,
  output logic             CORE_START,
  output logic             BUSY,
  output logic             READY,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] CYCLES,
  output logic [2:0]       STATE
);

  state_e           r_state;
  logic             r_done_q;
  logic             r_load;
  logic             r_clr;
  logic             r_core_start;
  logic             r_busy;
  logic             r_ready;
  logic             r_timeout;

  logic             w_done_rise;
  logic             w_tc;
  logic             w_timeout_hit;
  logic [CNT_W-1:0] w_limit;

  assign w_done_rise   = DONE & ~r_done_q;
  assign w_limit       = TIMEOUT_CYCLES - CNT_W'(1);
  assign w_timeout_hit = (TIMEOUT_CYCLES != '0) && w_tc;

  // Counts every edge spent in RUN, including the one that leaves it.
  rsa_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_clr   (r_state == ST_CLEAR),
    .i_en    (r_state == ST_RUN),
    .i_limit (w_limit),
    .o_count (CYCLES),
    .o_tc    (w_tc)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_done_q     <= 1'b0;
      r_load       <= 1'b0;
      r_clr        <= 1'b0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_done_q     <= DONE;
      r_load       <= 1'b0;
      r_clr        <= 1'b0;
      r_core_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (CMD_START) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_clr <= 1'b1;
          if (CMD_ABORT) begin
            r_state <= ST_ABORTED;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_load <= 1'b1;
          if (CMD_ABORT) begin
            r_state <= ST_ABORTED;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          // A DONE still high here is left over from the previous result.
          if (CMD_ABORT) begin
            r_state <= ST_ABORTED;
            r_busy  <= 1'b0;
          end else if (!DONE) begin
            r_core_start <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (CMD_ABORT) begin
            r_state <= ST_ABORTED;
            r_busy  <= 1'b0;
          end else if (w_done_rise) begin
            r_state <= ST_COMPLETE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_timeout_hit) begin
            r_state   <= ST_FAULT;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        ST_COMPLETE: begin
          if (CMD_ACK) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
          end
        end
        ST_FAULT: begin
          if (CMD_ACK) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b0;
          end
        end
        ST_ABORTED: begin
          r_clr   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign LOAD       = r_load;
  assign CLR        = r_clr;
  assign CORE_START = r_core_start;
  assign BUSY       = r_busy;
  assign READY      = r_ready;
  assign TIMEOUT    = r_timeout;
  assign STATE      = r_state;

endmodule

// File: tb/tb_rsa_sequencer.sv
// Directed bench for rsa_sequencer: a per-cycle vector table for the command
// handshake plus hand-written sequences for stale DONE, timeout, abort and reset.
module tb_rsa_sequencer;

  logic        CLK;
  logic        RESET_N;
  logic        CMD_START;
  logic        CMD_ABORT;
  logic        CMD_ACK;
  logic        DONE;

  logic        load, clr, cs, busy, ready, tmo;
  logic [31:0] cycles;
  logic [2:0]  state;

  logic        load50, clr50, cs50, busy50, ready50, tmo50;
  logic [31:0] cycles50;
  logic [2:0]  state50;

  logic        loads, clrs, css, busys, readys, tmos;
  logic [3:0]  cycless;
  logic [2:0]  states;

  int n_pass;
  int n_total;

  rsa_sequencer u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT),
    .CMD_ACK(CMD_ACK), .DONE(DONE), .LOAD(load), .CLR(clr), .CORE_START(cs),
    .BUSY(busy), .READY(ready), .TIMEOUT(tmo), .CYCLES(cycles), .STATE(state)
  );

  rsa_sequencer #(.TIMEOUT_CYCLES(32'd50)) u_dut50 (
    .CLK(CLK), .RESET_N(RESET_N), .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT),
    .CMD_ACK(CMD_ACK), .DONE(DONE), .LOAD(load50), .CLR(clr50), .CORE_START(cs50),
    .BUSY(busy50), .READY(ready50), .TIMEOUT(tmo50), .CYCLES(cycles50), .STATE(state50)
  );

  rsa_sequencer #(.CNT_W(4), .TIMEOUT_CYCLES(4'd0)) u_sat (
    .CLK(CLK), .RESET_N(RESET_N), .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT),
    .CMD_ACK(CMD_ACK), .DONE(DONE), .LOAD(loads), .CLR(clrs), .CORE_START(css),
    .BUSY(busys), .READY(readys), .TIMEOUT(tmos), .CYCLES(cycless), .STATE(states)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       st;
    logic       ab;
    logic       ak;
    logic       dn;
    logic [8:0] exp;
    string      name;
  } vec_t;

  // {LOAD, CLR, CORE_START, BUSY, READY, TIMEOUT, STATE}
  function automatic logic [8:0] mk(input logic l, input logic c, input logic s,
                                    input logic b, input logic r, input logic t,
                                    input logic [2:0] st);
    return {l, c, s, b, r, t, st};
  endfunction

  function automatic logic [8:0] outv();
    return {load, clr, cs, busy, ready, tmo, state};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    CMD_START = 1'b0;
    CMD_ABORT = 1'b0;
    CMD_ACK   = 1'b0;
    DONE      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  // Pulses START and returns in the first RUN cycle, when CORE_START is high.
  task automatic start_op();
    int k;
    CMD_START = 1'b1;
    tick();
    CMD_START = 1'b0;
    k = 0;
    while (!cs && k < 10) begin
      tick();
      k++;
    end
    chk("core_start_seen", {63'd0, cs}, 64'd1);
  endtask

  vec_t tbl[7];

  initial begin
    int seen;
    n_pass  = 0;
    n_total = 0;
    RESET_N = 1'b0;
    idle_inputs();

    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,3'd0), "idle_ignores_abort"};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,0,3'd0), "idle_ignores_ack"};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,1,0,0,3'd1), "enter_clear"};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0,1,0,1,0,0,3'd2), "clr_pulse"};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1,0,0,1,0,0,3'd3), "load_pulse"};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0,0,1,1,0,0,3'd4), "core_start_pulse"};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0,0,0,1,0,0,3'd4), "run_no_strobes"};

    // Reset state
    do_reset();
    chk("reset_outputs", {55'd0, outv()}, {55'd0, mk(0,0,0,0,0,0,3'd0)});
    chk("reset_cycles", {32'd0, cycles}, 64'd0);

    // Normal run: handshake from the table, then DONE rises in RUN cycle 100
    for (int i = 0; i < 7; i++) begin
      CMD_START = tbl[i].st;
      CMD_ABORT = tbl[i].ab;
      CMD_ACK   = tbl[i].ak;
      DONE      = tbl[i].dn;
      tick();
      chk(tbl[i].name, {55'd0, outv()}, {55'd0, tbl[i].exp});
    end
    idle_inputs();
    chk("run_cycles_after_2", {32'd0, cycles}, 64'd1);
    repeat (98) tick();
    DONE = 1'b1;
    #1;
    chk("ready_not_before_edge", {63'd0, ready}, 64'd0);
    tick();
    chk("complete_outputs", {55'd0, outv()}, {55'd0, mk(0,0,0,0,1,0,3'd5)});
    chk("complete_cycles", {32'd0, cycles}, 64'd100);
    CMD_START = 1'b1;
    tick();
    tick();
    CMD_START = 1'b0;
    chk("start_ignored_while_ready", {55'd0, outv()}, {55'd0, mk(0,0,0,0,1,0,3'd5)});
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    chk("after_ack", {55'd0, outv()}, {55'd0, mk(0,0,0,0,0,0,3'd0)});
    chk("cycles_held_in_idle", {32'd0, cycles}, 64'd100);

    // Stale DONE held high when reaching START
    do_reset();
    DONE = 1'b1;
    CMD_START = 1'b1;
    tick();
    CMD_START = 1'b0;
    tick();
    tick();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (state != 3'd3 || cs) seen++;
    end
    chk("stale_done_holds_start", seen, 0);
    DONE = 1'b0;
    tick();
    chk("stale_release_core_start", {55'd0, outv()}, {55'd0, mk(0,0,1,1,0,0,3'd4)});
    CMD_ABORT = 1'b1;
    tick();
    CMD_ABORT = 1'b0;
    tick();

    // Timeout at 50 cycles, core never finishes
    do_reset();
    start_op();
    repeat (49) tick();
    chk("pre_timeout_state", {61'd0, state50}, 64'd4);
    tick();
    chk("timeout_flag", {63'd0, tmo50}, 64'd1);
    chk("timeout_busy", {63'd0, busy50}, 64'd0);
    chk("timeout_state", {61'd0, state50}, 64'd6);
    chk("timeout_cycles", {32'd0, cycles50}, 64'd50);
    tick();
    chk("timeout_held", {62'd0, tmo50, ready50}, 64'd2);
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    chk("timeout_ack_idle", {60'd0, tmo50, state50}, 64'd0);

    // DONE rises in the terminal cycle: completion beats timeout
    do_reset();
    start_op();
    repeat (49) tick();
    DONE = 1'b1;
    tick();
    chk("simul_ready", {62'd0, ready50, tmo50}, 64'd2);
    chk("simul_state", {61'd0, state50}, 64'd5);
    chk("simul_cycles", {32'd0, cycles50}, 64'd50);
    idle_inputs();
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;

    // Abort at RUN cycle 20
    do_reset();
    start_op();
    repeat (19) tick();
    CMD_ABORT = 1'b1;
    tick();
    CMD_ABORT = 1'b0;
    chk("aborted_state", {55'd0, outv()}, {55'd0, mk(0,0,0,0,0,0,3'd7)});
    tick();
    chk("abort_clr_pulse", {55'd0, outv()}, {55'd0, mk(0,1,0,0,0,0,3'd0)});
    tick();
    chk("abort_clr_single", {63'd0, clr}, 64'd0);
    chk("abort_cycles", {32'd0, cycles}, 64'd20);
    DONE = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (outv() != mk(0,0,0,0,0,0,3'd0)) seen++;
    end
    chk("late_done_ignored", seen, 0);
    DONE = 1'b0;

    // Abort sampled in LOAD: LOAD finishes, no CORE_START ever
    do_reset();
    CMD_START = 1'b1;
    tick();
    CMD_START = 1'b0;
    tick();
    CMD_ABORT = 1'b1;
    tick();
    CMD_ABORT = 1'b0;
    chk("abort_in_load", {55'd0, outv()}, {55'd0, mk(1,0,0,0,0,0,3'd7)});
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cs || state != 3'd0) seen++;
    end
    chk("abort_in_load_no_core_start", seen, 0);

    // Reset asserted for one edge at RUN cycle 10
    do_reset();
    start_op();
    repeat (9) tick();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    chk("midrun_reset_outputs", {55'd0, outv()}, {55'd0, mk(0,0,0,0,0,0,3'd0)});
    chk("midrun_reset_cycles", {32'd0, cycles}, 64'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cs || state != 3'd0) seen++;
    end
    chk("midrun_reset_stays_idle", seen, 0);

    // Zero timeout never faults; narrow counter saturates
    do_reset();
    start_op();
    repeat (25) tick();
    chk("sat_cycles", {60'd0, cycless}, 64'd15);
    chk("sat_no_timeout", {60'd0, tmos, states}, 64'd4);
    CMD_ABORT = 1'b1;
    tick();
    CMD_ABORT = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
